csr_irq_unit: RTL

CSR_IRQ_UNIT -- requirements
Module: csr_irq_unit

---
 rtl/csr_irq_unit.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/csr_irq_unit.sv
// csr_irq_unit
//   Machine-mode CSR file and interrupt controller for a single-hart RV32 core.
//   Holds mstatus/mie/mip/mtvec/mepc/mcause/mtval, the optional 64-bit
//   mcycle/minstret counters with mcountinhibit, prioritises pending
//   interrupts and produces the trap vector for the trap unit.
//
// Ports
//   clk, rst          : single clock, synchronous active-high reset
//   csr_we            : CSR write request for the current instruction
//   csr_addr          : 12-bit CSR address
//   csr_wdata         : rs1 value or zero-extended uimm
//   csr_op            : funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
//   csr_rdata         : value of the addressed CSR before this cycle's update
//   csr_illegal       : write to an unimplemented or read-only CSR
//   trap_taken        : trap entry this cycle (trap_pc/trap_cause/trap_tval valid)
//   mret_exec         : mret retiring this cycle
//   instret_i         : one instruction retired this cycle
//   irq_ext/timer/soft: level-sensitive machine interrupt lines
//   irq_plat          : level-sensitive platform interrupt lines (mip[16+])
//   irq_pending_o     : an enabled interrupt is pending and mstatus.MIE is set
//   irq_cause_o       : mcause value for the highest-priority pending interrupt
//   trap_vector_o     : trap target PC for trap_cause
//   mepc_o, mstatus_o : registered mepc and mstatus
module csr_irq_unit #(
  parameter logic [31:0] MISA_VAL     = 32'h4000_1100,
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
  parameter int          NUM_PLAT_IRQ = 4,
  parameter int          HAS_COUNTERS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic [2:0]  csr_op,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        trap_taken,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_tval,
  input  logic        mret_exec,
  input  logic        instret_i,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        irq_soft,
  input  logic [((NUM_PLAT_IRQ > 0) ? NUM_PLAT_IRQ : 1)-1:0] irq_plat,
  output logic        irq_pending_o,
  output logic [31:0] irq_cause_o,
  output logic [31:0] trap_vector_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mstatus_o
);

  localparam logic        HAS_CNT   = (HAS_COUNTERS != 0);
  localparam logic [31:0] PLAT_MASK = (32'h0000_FFFF >> (16 - NUM_PLAT_IRQ)) << 16;
  // MSIP, MTIP, MEIP plus the platform lines: the only bits mie/mip carry.
  localparam logic [31:0] IRQ_MASK  = 32'h0000_0888 | PLAT_MASK;
  localparam logic [31:0] INH_MASK  = 32'h0000_0005;

  // Returns {op_valid, new_value}; unknown funct3 encodings report invalid.
  function automatic logic [32:0] csr_modify(input logic [2:0]  op,
                                             input logic [31:0] old_val,
                                             input logic [31:0] wval);
    logic [32:0] res;
    case (op)
      3'b001, 3'b101: res = {1'b1, wval};
      3'b010, 3'b110: res = {1'b1, old_val | wval};
      3'b011, 3'b111: res = {1'b1, old_val & ~wval};
      default:        res = {1'b0, old_val};
    endcase
    return res;
  endfunction

  // Architectural state
  logic        st_mie_q, st_mpie_q;
  logic [31:0] mie_q, mip_q, mtvec_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle_q, minstret_q;
  logic [31:0] mcountinhibit_q;

  // Next-state values
  logic        st_mie_d, st_mpie_d;
  logic [31:0] mie_d, mip_d, mtvec_d, mepc_d, mcause_d, mtval_d;
  logic [63:0] mcycle_d, minstret_d;
  logic [31:0] mcountinhibit_d;

  logic [31:0] mstatus_val;
  logic [31:0] rd_val;
  logic        addr_impl;
  logic        wr_ok;
  logic [32:0] mod_res;
  logic [31:0] wval;
  logic        wr_en;
  logic [31:0] irq_vec;
  logic [31:0] irq_en;
  logic [4:0]  irq_code;

  // MPP is hard-wired to machine mode.
  assign mstatus_val = {19'd0, 2'b11, 3'd0, st_mpie_q, 3'd0, st_mie_q, 3'd0};

  // Read mux: always reflects registered state, never this cycle's write.
  always_comb begin
    rd_val    = 32'd0;
    addr_impl = 1'b1;
    case (csr_addr)
      12'h300: rd_val = mstatus_val;
      12'h301: rd_val = MISA_VAL;
      12'h304: rd_val = mie_q;
      12'h305: rd_val = mtvec_q;
      12'h341: rd_val = mepc_q;
      12'h342: rd_val = mcause_q;
      12'h343: rd_val = mtval_q;
      12'h344: rd_val = mip_q;
      12'hF14: rd_val = 32'd0;
      12'hB00, 12'hC00: begin
        addr_impl = HAS_CNT;
        rd_val    = HAS_CNT ? mcycle_q[31:0] : 32'd0;
      end
      12'hB80, 12'hC80: begin
        addr_impl = HAS_CNT;
        rd_val    = HAS_CNT ? mcycle_q[63:32] : 32'd0;
      end
      12'hB02, 12'hC02: begin
        addr_impl = HAS_CNT;
        rd_val    = HAS_CNT ? minstret_q[31:0] : 32'd0;
      end
      12'hB82, 12'hC82: begin
        addr_impl = HAS_CNT;
        rd_val    = HAS_CNT ? minstret_q[63:32] : 32'd0;
      end
      12'h320: begin
        addr_impl = HAS_CNT;
        rd_val    = HAS_CNT ? mcountinhibit_q : 32'd0;
      end
      default: addr_impl = 1'b0;
    endcase
  end

  assign csr_rdata   = rd_val;
  assign csr_illegal = csr_we & (~addr_impl | (csr_addr[11:10] == 2'b11));

  assign mod_res = csr_modify(csr_op, rd_val, csr_wdata);
  assign wr_ok   = mod_res[32];
  assign wval    = mod_res[31:0];
  // Trap entry and mret both take precedence and drop the CSR write outright.
  assign wr_en   = csr_we & ~csr_illegal & wr_ok & ~trap_taken & ~mret_exec;

  // Interrupt lines into their mip bit positions.
  always_comb begin
    irq_vec     = 32'd0;
    irq_vec[3]  = irq_soft;
    irq_vec[7]  = irq_timer;
    irq_vec[11] = irq_ext;
    for (int i = 0; i < NUM_PLAT_IRQ; i++) begin
      irq_vec[16+i] = irq_plat[i];
    end
  end

  assign irq_en = mip_q & mie_q;

  // Later assignments win: lowest platform line, then MTIP, MSIP, MEIP.
  always_comb begin
    irq_code = 5'd0;
    for (int i = 31; i >= 16; i--) begin
      if (irq_en[i]) irq_code = 5'(i);
    end
    if (irq_en[7])  irq_code = 5'd7;
    if (irq_en[3])  irq_code = 5'd3;
    if (irq_en[11]) irq_code = 5'd11;
  end

  assign irq_pending_o = st_mie_q & (|irq_en);
  assign irq_cause_o   = irq_pending_o ? {1'b1, 26'd0, irq_code} : 32'd0;

  // Vectored mode offsets only interrupts; 4*cause wraps to 32 bits.
  assign trap_vector_o = {mtvec_q[31:2], 2'b00} +
                         ((mtvec_q[0] && trap_cause[31]) ? {trap_cause[29:0], 2'b00} : 32'd0);

  assign mepc_o    = mepc_q;
  assign mstatus_o = mstatus_val;

  // Next-state: trap > mret > CSR write; counters advance independently.
  always_comb begin
    st_mie_d        = st_mie_q;
    st_mpie_d       = st_mpie_q;
    mie_d           = mie_q;
    mip_d           = irq_vec & IRQ_MASK;
    mtvec_d         = mtvec_q;
    mepc_d          = mepc_q;
    mcause_d        = mcause_q;
    mtval_d         = mtval_q;
    mcountinhibit_d = mcountinhibit_q;
    mcycle_d        = mcountinhibit_q[0] ? mcycle_q : mcycle_q + 64'd1;
    minstret_d      = (instret_i && !mcountinhibit_q[2]) ? minstret_q + 64'd1 : minstret_q;

    if (trap_taken) begin
      mepc_d    = trap_pc & ~32'd3;
      mcause_d  = trap_cause;
      mtval_d   = trap_tval;
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
    end else if (mret_exec) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        12'h300: begin
          st_mie_d  = wval[3];
          st_mpie_d = wval[7];
        end
        12'h304: mie_d           = wval & IRQ_MASK;
        12'h305: mtvec_d         = wval & ~32'd2;
        12'h341: mepc_d          = wval & ~32'd3;
        12'h342: mcause_d        = wval;
        12'h343: mtval_d         = wval;
        // Writing a counter half replaces it and skips this cycle's increment.
        12'hB00: mcycle_d        = {mcycle_q[63:32], wval};
        12'hB80: mcycle_d        = {wval, mcycle_q[31:0]};
        12'hB02: minstret_d      = {minstret_q[63:32], wval};
        12'hB82: minstret_d      = {wval, minstret_q[31:0]};
        12'h320: mcountinhibit_d = wval & INH_MASK;
        default: ; // misa and mip are WARL: accepted, value unchanged
      endcase
    end

    if (!HAS_CNT) begin
      mcycle_d        = 64'd0;
      minstret_d      = 64'd0;
      mcountinhibit_d = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_mie_q        <= 1'b0;
      st_mpie_q       <= 1'b0;
      mie_q           <= 32'd0;
      mip_q           <= 32'd0;
      mtvec_q         <= MTVEC_RESET & ~32'd2;
      mepc_q          <= 32'd0;
      mcause_q        <= 32'd0;
      mtval_q         <= 32'd0;
      mcycle_q        <= 64'd0;
      minstret_q      <= 64'd0;
      mcountinhibit_q <= 32'd0;
    end else begin
      st_mie_q        <= st_mie_d;
      st_mpie_q       <= st_mpie_d;
      mie_q           <= mie_d;
      mip_q           <= mip_d;
      mtvec_q         <= mtvec_d;
      mepc_q          <= mepc_d;
      mcause_q        <= mcause_d;
      mtval_q         <= mtval_d;
      mcycle_q        <= mcycle_d;
      minstret_q      <= minstret_d;
      mcountinhibit_q <= mcountinhibit_d;
    end
  end

endmodule
